// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree feeding a multi-beat accumulator; one result per ACC_BEATS beats.
// Valid/ready on both sides; the group sum is clamped or wrapped to WIDTH_SUM bits.
module adder_tree_acc #(
  parameter int WIDTH_ADDEND = 8,
  parameter int NUM_LANES    = 8,
  parameter int ACC_BEATS    = 4,
  parameter int WIDTH_SUM    = 16,
  parameter bit SATURATE     = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_LANES*WIDTH_ADDEND-1:0] in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [WIDTH_SUM-1:0]       out_sum,
  output logic                              out_overflow
);

  localparam int L  = $clog2(NUM_LANES);
  localparam int WT = WIDTH_ADDEND + L;
  localparam int WA = WT + $clog2(ACC_BEATS) + 1;
  localparam int CW = (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;

  logic                        en;
  logic                        out_valid_reg;
  logic signed [WIDTH_SUM-1:0] out_sum_reg;
  logic                        out_ovf_reg;

  // A held, unconsumed result stalls the whole pipeline.
  assign en        = !(out_valid_reg && !out_ready);
  assign in_ready  = en;
  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_overflow = out_ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi <= L; gi++) begin : g_stage
      localparam int N  = NUM_LANES >> gi;
      localparam int SW = WIDTH_ADDEND + gi;
      logic signed [SW-1:0] node [N];
      logic                 vld;

      if (gi == 0) begin : g_in
        for (genvar gj = 0; gj < N; gj++) begin : g_lane
          assign node[gj] = in_data[gj*WIDTH_ADDEND +: WIDTH_ADDEND];
        end
        assign vld = in_valid && en;
      end else begin : g_add
        always_ff @(posedge clk) begin
          if (rst) begin
            vld <= 1'b0;
          end else if (en) begin
            vld <= g_stage[gi-1].vld;
          end
        end

        // Each level grows by one bit, so pairwise sums never overflow.
        always_ff @(posedge clk) begin
          if (en) begin
            for (int j = 0; j < N; j++) begin
              node[j] <= SW'(g_stage[gi-1].node[2*j]) + SW'(g_stage[gi-1].node[2*j+1]);
            end
          end
        end
      end
    end
  endgenerate

  logic signed [WT-1:0] tree;
  logic                 tree_vld;
  assign tree     = g_stage[L].node[0];
  assign tree_vld = g_stage[L].vld;

  logic signed [WA-1:0] acc_reg;
  logic signed [WA-1:0] acc_base;
  logic signed [WA-1:0] tree_ext;
  logic signed [WA-1:0] sum_exact;
  logic [CW-1:0]        beat_cnt_reg;
  logic                 last_beat;

  assign last_beat = (beat_cnt_reg == CW'(ACC_BEATS - 1));
  assign acc_base  = (beat_cnt_reg == '0) ? '0 : acc_reg;
  assign tree_ext  = WA'(tree);
  assign sum_exact = acc_base + tree_ext;

  logic signed [WIDTH_SUM-1:0] fit_sum;
  logic                        fit_ovf;

  generate
    if (WIDTH_SUM >= WA) begin : g_fit_wide
      assign fit_sum = WIDTH_SUM'(sum_exact);
      assign fit_ovf = 1'b0;
    end else begin : g_fit_narrow
      logic [WA-WIDTH_SUM:0] upper;
      assign upper   = sum_exact[WA-1:WIDTH_SUM-1];
      // In range exactly when all bits from the result sign bit upward agree.
      assign fit_ovf = !((&upper) || !(|upper));
      if (SATURATE) begin : g_sat
        assign fit_sum = !fit_ovf ? sum_exact[WIDTH_SUM-1:0] :
                         sum_exact[WA-1] ? {1'b1, {(WIDTH_SUM-1){1'b0}}} :
                                           {1'b0, {(WIDTH_SUM-1){1'b1}}};
      end else begin : g_wrap
        assign fit_sum = sum_exact[WIDTH_SUM-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      beat_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_ovf_reg   <= 1'b0;
    end else if (en) begin
      out_valid_reg <= tree_vld && last_beat;
      if (tree_vld) begin
        acc_reg      <= sum_exact;
        beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + 1'b1;
        if (last_beat) begin
          out_sum_reg <= fit_sum;
          out_ovf_reg <= fit_ovf;
        end
      end
    end
  end

endmodule
